// File: rtl/fir_stream_ctrl.sv
// Sequencer for one FIR channel: coefficient load, credit-limited sample admission, frame drain tracking.
// Handshakes are decoded combinationally from state; the credit count and done pulse are registered.
module fir_stream_ctrl #(
    parameter int CREDITS  = 32,
    parameter int MAX_TAPS = 64,
    parameter int TAPW     = $clog2(MAX_TAPS + 1),
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TAPW-1:0] num_taps,
    input  logic            coef_valid,
    output logic            coef_ready,
    output logic            coef_we,
    output logic [TAPW-1:0] coef_addr,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic            ip_valid,
    output logic            ip_last,
    input  logic            out_pop,
    input  logic            out_last,
    output logic [CW-1:0]   inflight,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    state_t          state;
    logic [TAPW-1:0] taps_q;
    logic            last_seen;
    logic [CW-1:0]   inflight_nxt;
    logic            underflow;
    logic            last_hit;
    logic            drain_exit;

    // Readies are held low while rst is high so nothing is accepted in the reset cycle.
    always_comb begin
        coef_ready = (state == S_LOAD) && !rst;
        in_ready   = (state == S_RUN) && (inflight < CRED_MAX) && !rst;
        coef_we    = coef_valid && coef_ready;
        ip_valid   = in_valid && in_ready;
        ip_last    = ip_valid && in_last;
        busy       = (state != S_IDLE);
    end

    // A pop with nothing in flight and no simultaneous issue clamps at zero and flags an error.
    always_comb begin
        underflow    = out_pop && !ip_valid && (inflight == '0);
        inflight_nxt = inflight;
        case ({ip_valid, out_pop})
            2'b10:   inflight_nxt = inflight + CW'(1);
            2'b01:   inflight_nxt = underflow ? '0 : inflight - CW'(1);
            default: inflight_nxt = inflight;
        endcase
        last_hit   = out_pop && out_last;
        drain_exit = (state == S_DRAIN) && (inflight_nxt == '0) && (last_seen || last_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            taps_q    <= '0;
            coef_addr <= '0;
            inflight  <= '0;
            last_seen <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= inflight_nxt;
            if (underflow)
                err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        taps_q    <= num_taps;
                        coef_addr <= '0;
                        last_seen <= 1'b0;
                        state     <= (num_taps != '0) ? S_LOAD : S_RUN;
                    end
                end
                S_LOAD: begin
                    if (coef_we) begin
                        if (coef_addr == taps_q - TAPW'(1)) begin
                            coef_addr <= '0;
                            state     <= S_RUN;
                        end else begin
                            coef_addr <= coef_addr + TAPW'(1);
                        end
                    end
                end
                S_RUN: begin
                    // An early out_last is remembered so the drain can still finish on it.
                    if (last_hit)
                        last_seen <= 1'b1;
                    if (ip_valid && in_last)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (last_hit)
                        last_seen <= 1'b1;
                    if (drain_exit) begin
                        last_seen <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with scoreboard queues for coefficient and sample issue.
module tb_fir_stream_ctrl;

    localparam int TAPW = 7;
    localparam int CW   = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [TAPW-1:0] num_taps;
    logic            coef_valid;
    logic            coef_ready;
    logic            coef_we;
    logic [TAPW-1:0] coef_addr;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic            ip_valid;
    logic            ip_last;
    logic            out_pop;
    logic            out_last;
    logic [CW-1:0]   inflight;
    logic            busy;
    logic            done;
    logic            err;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int model_inf   = 0;

    int   exp_addr_q[$];
    logic exp_last_q[$];

    always #5 clk = ~clk;

    fir_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_taps(num_taps),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .ip_valid(ip_valid), .ip_last(ip_last),
        .out_pop(out_pop), .out_last(out_last),
        .inflight(inflight), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: pops expectations when the DUT emits a strobe.
    always @(negedge clk) begin
        #1;
        if (coef_we === 1'b1) begin
            if (exp_addr_q.size() == 0) chk("coef_unexpected", 32'd1, 32'd0);
            else chk("coef_addr", 32'(coef_addr), 32'(exp_addr_q.pop_front()));
        end
        if (ip_valid === 1'b1) begin
            if (exp_last_q.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
            else chk("ip_last", 32'(ip_last), 32'(exp_last_q.pop_front()));
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; num_taps = '0; coef_valid = 0; in_valid = 0; in_last = 0;
        out_pop = 0; out_last = 0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_busy", busy, 0);       chk("rst_inflight", inflight, 0);
        chk("rst_err", err, 0);         chk("rst_done", done, 0);
        chk("rst_coef_ready", coef_ready, 0); chk("rst_in_ready", in_ready, 0);
        chk("rst_coef_addr", coef_addr, 0);
        cyc(); rst = 0;

        // 1: four-tap load, single-sample frame
        start = 1; num_taps = 7'd4;
        cyc(); start = 0; coef_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("load_coef_ready", coef_ready, 1);
            exp_addr_q.push_back(i);
            cyc();
        end
        coef_valid = 0;
        @(negedge clk);
        chk("t1_run_in_ready", in_ready, 1); chk("t1_run_coef_ready", coef_ready, 0);
        cyc(); in_valid = 1; in_last = 1;
        @(negedge clk); exp_last_q.push_back(1'b1);
        cyc(); in_valid = 0; in_last = 0;
        @(negedge clk);
        chk("t1_inflight1", inflight, 1); chk("t1_drain_in_ready", in_ready, 0); chk("t1_busy", busy, 1);
        repeat (4) cyc();
        out_pop = 1; out_last = 1;
        cyc(); out_pop = 0; out_last = 0;
        @(negedge clk);
        chk("t1_inflight0", inflight, 0); chk("t1_done", done, 1);
        cyc();
        @(negedge clk);
        chk("t1_done_pulse", done, 0); chk("t1_busy_low", busy, 0); chk("t1_done_cnt", done_cnt, 1);

        // 2: credit stall with zero taps
        cyc(); start = 1; num_taps = 7'd0;
        cyc(); start = 0; in_valid = 1; model_inf = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            chk("t2_in_ready", in_ready, (model_inf < 32) ? 1 : 0);
            if (model_inf < 32) begin
                exp_last_q.push_back(1'b0);
                model_inf++;
            end
            cyc();
        end
        @(negedge clk);
        chk("t2_full", inflight, 32); chk("t2_stall", in_ready, 0);
        cyc(); out_pop = 1;
        @(negedge clk); chk("t2_pop_cycle_ready", in_ready, 0);
        cyc(); out_pop = 0; model_inf--;
        @(negedge clk);
        chk("t2_after_pop", inflight, 31); chk("t2_ready_again", in_ready, 1);
        exp_last_q.push_back(1'b0); model_inf++;
        cyc(); in_valid = 0;
        @(negedge clk); chk("t2_refill", inflight, 32);

        // 3: drain to 10, then simultaneous issue and pop; start in RUN is ignored
        out_pop = 1;
        repeat (22) cyc();
        out_pop = 0;
        @(negedge clk); chk("t3_at10", inflight, 10);
        cyc(); in_valid = 1; out_pop = 1; start = 1; num_taps = 7'd5;
        @(negedge clk); exp_last_q.push_back(1'b0);
        cyc(); in_valid = 0; out_pop = 0; start = 0;
        @(negedge clk);
        chk("t3_stays10", inflight, 10); chk("t3_err", err, 0); chk("t3_still_run", in_ready, 1);
        cyc(); in_valid = 1; in_last = 1;
        @(negedge clk); exp_last_q.push_back(1'b1);
        cyc(); in_valid = 0; in_last = 0;
        // 6: start during DRAIN, including on the final pop
        for (int k = 0; k < 11; k++) begin
            out_pop = 1; out_last = (k == 10); start = (k == 3 || k == 10);
            @(negedge clk);
            if (k == 5) chk("t6_drain_busy", busy, 1);
            cyc();
        end
        out_pop = 0; out_last = 0; start = 0;
        @(negedge clk);
        chk("t6_done", done, 1); chk("t6_inflight", inflight, 0); chk("t6_idle", busy, 0);
        cyc();
        @(negedge clk);
        chk("t6_no_load", coef_ready, 0); chk("t6_idle2", busy, 0); chk("t6_done_cnt", done_cnt, 2);

        // 4: underflow in IDLE
        out_pop = 1;
        cyc(); out_pop = 0;
        @(negedge clk);
        chk("t4_err", err, 1); chk("t4_inflight", inflight, 0); chk("t4_idle", busy, 0);
        cyc(); cyc();
        @(negedge clk); chk("t4_err_sticky", err, 1);

        // 5: reset in the middle of a load
        cyc(); start = 1; num_taps = 7'd8;
        cyc(); start = 0; coef_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); exp_addr_q.push_back(i);
            cyc();
        end
        coef_valid = 0; rst = 1;
        cyc(); rst = 0;
        @(negedge clk);
        chk("t5_idle", busy, 0); chk("t5_addr", coef_addr, 0); chk("t5_inflight", inflight, 0);
        chk("t5_err_cleared", err, 0); chk("t5_no_done", done_cnt, 2);
        cyc(); start = 1; num_taps = 7'd2;
        cyc(); start = 0; coef_valid = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); exp_addr_q.push_back(i);
            cyc();
        end
        coef_valid = 0;
        @(negedge clk); chk("t5_run", in_ready, 1);
        cyc(); in_valid = 1; in_last = 1;
        @(negedge clk); exp_last_q.push_back(1'b1);
        cyc(); in_valid = 0; in_last = 0; out_pop = 1; out_last = 1;
        cyc(); out_pop = 0; out_last = 0;
        @(negedge clk); chk("t5_done", done, 1);
        cyc(); cyc();
        @(negedge clk);
        chk("t5_done_cnt", done_cnt, 3);
        chk("coef_q_empty", exp_addr_q.size(), 0);
        chk("issue_q_empty", exp_last_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_stream_ctrl.md
Name: fir_stream_ctrl

Overview:
Sequencing controller for one FIR channel. It loads coefficients into the FIR IP, then admits input samples under a credit scheme so the 32-entry output FIFO stage can never overflow. It tracks each frame from its first accepted sample to the pop of its last output, then signals completion. It sits between the upstream input interface, the FIR IP and the output FIFO stage, and consumes that stage's per-pop "data left" indication.

Parameters:
CREDITS, 32, maximum samples in flight (issued to the IP but not yet popped from the output stage); equals the output FIFO depth.
MAX_TAPS, 64, maximum coefficient count per load.
TAPW, $clog2(MAX_TAPS+1), width of the tap-count config.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a coefficient load plus one frame; sampled in IDLE only
num_taps  in  TAPW  coefficients to load; latched when start is accepted
coef_valid  in  1  upstream coefficient valid
coef_ready  out  1  coefficient accepted when coef_valid & coef_ready
coef_we  out  1  write strobe to the IP coefficient bank; equals the accept
coef_addr  out  TAPW  coefficient index; 0 for the first coefficient
in_valid  in  1  upstream sample valid
in_last  in  1  upstream end-of-frame flag, qualified by in_valid
in_ready  out  1  sample accepted when in_valid & in_ready
ip_valid  out  1  sample issue strobe to the IP; equals the accept
ip_last  out  1  in_last of the issued sample; feeds the output stage tlast_in
out_pop  in  1  one output popped from the output stage (its tx_to_cont.valid)
out_last  in  1  last flag of the popped output, qualified by out_pop
inflight  out  $clog2(CREDITS+1)  current in-flight count
busy  out  1  high when the state is not IDLE
done  out  1  one-cycle pulse on the DRAIN->IDLE transition
err  out  1  sticky pop-underflow flag; cleared only by rst

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is synchronous and active-high; it takes priority over every other input.
  - On reset: state=IDLE, inflight=0, coef_addr=0, tap counter=0, err=0, done=0.
  - On reset, all ready and strobe outputs are 0.
  - Reset mid-frame abandons the frame with no done pulse.
- State machine (registered state; handshake outputs decoded combinationally from state and counters):
  - IDLE: coef_ready=0, in_ready=0.
    - On start: latch num_taps; next state LOAD if num_taps!=0, else RUN.
  - LOAD: coef_ready=1.
    - Each accept writes coef_addr, then increments it.
    - The accept of coefficient num_taps-1 moves to RUN on the next cycle; coef_addr returns to 0.
  - RUN: in_ready = (inflight < CREDITS).
    - The accept that carries in_last moves to DRAIN; in_ready deasserts on the following cycle.
  - DRAIN: in_ready=0, coef_ready=0.
    - Exit to IDLE with done=1 when the next-cycle inflight is 0 and the frame's out_last has been popped.
    - The out_last pop may coincide with the final decrement.
- start outside IDLE is ignored. start and a frame's final pop in the same cycle: the start is ignored, because the state is still DRAIN.
- Credit counter, updated every cycle:
  - +1 on ip_valid.
  - -1 on out_pop.
  - Both in the same cycle: unchanged.
- inflight never exceeds CREDITS; this is guaranteed by in_ready. Issue and pop in the same cycle at inflight=CREDITS is legal, but in_ready is already 0 that cycle.
- out_pop while inflight=0 and no issue in the same cycle:
  - err set (sticky);
  - count stays 0, no wrap;
  - state is unaffected.
- out_last seen in RUN (spurious) is recorded and satisfies the DRAIN exit condition. It is not an error.
- Latency:
  - ip_valid is combinational from the in_valid/in_ready accept (zero added latency).
  - The inflight update is visible on the next cycle.
  - done asserts the cycle after the final pop.

Test Plan:
1. Coefficient load and single-sample frame: start with num_taps=4, then 4 back-to-back coefficients → coef_addr 0,1,2,3; RUN entered on the cycle after the 4th accept. Then issue 1 sample with in_last, then out_pop with out_last 5 cycles later → inflight 1→0, done one cycle after the pop, busy low thereafter.
2. Credit stall: num_taps=0, in_valid held high, no pops → exactly 32 accepts, then in_ready=0 with inflight=32. One out_pop → in_ready=1 the next cycle; 33rd sample accepted.
3. Simultaneous issue and pop at inflight=10 → inflight stays 10; err stays 0.
4. Underflow: out_pop in IDLE with inflight=0 → err=1 and persists; inflight=0; state remains IDLE.
5. Reset mid-frame: 3 coefficients loaded of num_taps=8, then rst for 1 cycle → IDLE, coef_addr=0, inflight=0, no done. A new start with num_taps=2 loads at addresses 0 and 1.
6. start asserted in RUN and DRAIN → ignored; num_taps re-latch is not observed; exactly one done per frame.
